barrier_painter: RTL and testbench
==================================

// Module: barrier_painter
// PURPOSE
//  Write-side stage for the fluid-state BRAM that the display pixel stage reads.
//  - After reset, and on request, it sweeps the whole grid to the equilibrium distribution.
//  - On a paint request it stamps a square brush of barrier cells around the cursor.
//    A barrier cell has all 9 densities = 8'hFF; the display renders these black.
//  - Erase mode instead restores the brush cells to equilibrium.
//  - Writes one cell per clock on the BRAM write port.
// PARAMETERS
//  GRID_W      205    cells per row; addr = x + GRID_W*y
//  GRID_H      154    rows
//  BRAM_DEPTH  31570  cells in BRAM (= GRID_W*GRID_H); AW = $clog2(BRAM_DEPTH)
//  BRUSH_R     2      brush half-width; brush is (2R+1)x(2R+1) cells
//  INIT_REST   8'd112 equilibrium density, direction 0 (rest)
//  INIT_AXIS   8'd28  equilibrium density, directions 1-4 (E,N,W,S)
//  INIT_DIAG   8'd7   equilibrium density, directions 5-8 (NE,NW,SW,SE)
// PORTS
//  pixel_clk_in   in   1        single clock; all logic on its rising edge
//  rst_n_in       in   1        async active-low reset
//  init_req_in    in   1        1-cycle pulse: start a full-grid equilibrium sweep
//  paint_req_in   in   1        1-cycle pulse: stamp brush at cursor
//  erase_in       in   1        sampled with paint_req_in; 1 = erase, 0 = draw barrier
//  cursor_x_in    in   8        brush centre column (values >= GRID_W allowed)
//  cursor_y_in    in   8        brush centre row (values >= GRID_H allowed)
//  wr_en_out      out  1        BRAM write enable
//  wr_addr_out    out  AW       BRAM write address
//  wr_data_out    out  [8:0][7:0] cell data; index = direction number
//  busy_out       out  1        high while INIT or PAINT is active
//  done_out       out  1        1-cycle pulse after the last write slot of an operation
// BEHAVIOUR
//  Reset values:
//  - While rst_n_in=0, all outputs are 0 and the FSM is forced to INIT with counters at 0.
//  - Reset mid-operation aborts it. No partial-state recovery; the sweep restarts at addr 0.
//  Outputs: all outputs are registered.
//  FSM: IDLE, INIT, PAINT, DONE.
//  - IDLE: init_req_in -> INIT; else paint_req_in -> PAINT.
//    - Both in the same cycle: INIT wins and the paint is dropped.
//    - Accepting paint latches cursor_x/y and erase_in.
//  - Requests are ignored, not queued, outside IDLE.
//  - INIT: one write slot per cycle, addr 0..BRAM_DEPTH-1 ascending.
//    - Data per slot: {INIT_DIAG x4, INIT_AXIS x4, INIT_REST} in [8:5], [4:1], [0].
//    - After the last slot (addr BRAM_DEPTH-1) -> DONE.
//  - PAINT: exactly (2R+1)^2 slots, row-major.
//    - dy = -R..R outer loop, dx = -R..R inner loop.
//    - Cell x = cx+dx, y = cy+dy, computed signed with >= 10 bits.
//    - Valid iff 0 <= x < GRID_W and 0 <= y < GRID_H. Valid slots assert wr_en_out.
//    - Clipped slots drive wr_en_out=0 but still take one cycle. Latency is fixed regardless of position.
//    - Data: draw = all 8'hFF; erase = the equilibrium vector above.
//    - Address is formed by incremental counters or a constant multiply. It must never exceed BRAM_DEPTH-1 when wr_en_out=1.
//    - After the last slot -> DONE.
//  - DONE: done_out=1, busy_out=0, wr_en_out=0 for one cycle -> IDLE.
//  Timing:
//  - Request accepted at edge N: first write slot visible after edge N+1. busy_out=1 from edge N+1.
//  - Paint: done_out asserted for the cycle after edge N+(2R+1)^2+1.
//  - After reset release: the first edge starts slot addr 0; done_out follows BRAM_DEPTH slots later.
//  - wr_data_out and wr_addr_out hold their last value when wr_en_out=0. The consumer must not rely on them then.
//  Overlap: cursor inputs changing during PAINT have no effect.
// TESTING
//  1. Reset release -> exactly 31570 writes, addr 0..31569 consecutive.
//     Every word {7,7,7,7,28,28,28,28,112}; busy high throughout; done_out once.
//  2. Draw at (100,50), R=2 -> 25 writes, all enabled, data all 8'hFF.
//     First addr 9938, last addr 10762, row stride 205; done 26 cycles after accept.
//  3. Draw at (0,0) -> 25 slots, 9 enabled.
//     Addrs 0,1,2,205,206,207,410,411,412; duration still 25 slots.
//     Also (204,153) -> 9 enabled, last addr 31569.
//  4. Erase at (10,10) after a draw there -> same 25 addrs written with the equilibrium vector.
//  5. paint_req during INIT -> ignored; simultaneous init_req+paint_req in IDLE -> only the full sweep runs.
//  6. rst_n_in low mid-PAINT (slot 12) -> outputs 0 immediately.
//     After release, a full INIT sweep from addr 0 with no residual paint writes.

Source files
------------

// File: rtl/barrier_painter_if.sv
// Bus bundle between the barrier painter and its surroundings.
// The request side (init/paint pulses plus cursor) comes from the UI logic.
// The write side goes to the fluid-state BRAM write port.
//
// Handshake: there is no valid/ready pair. init_req_in and paint_req_in are
// single-cycle pulses. They are honoured only while the painter is idle, and
// they are silently dropped otherwise. wr_en_out qualifies wr_addr_out and
// wr_data_out for exactly one clock per cell, and the BRAM must accept every
// enabled write. busy_out marks an operation in progress. done_out pulses
// once when an operation ends.
interface barrier_painter_if #(
    parameter int AW = 15
) ();
    logic                 init_req_in;
    logic                 paint_req_in;
    logic                 erase_in;
    logic [7:0]           cursor_x_in;
    logic [7:0]           cursor_y_in;
    logic                 wr_en_out;
    logic [AW-1:0]        wr_addr_out;
    logic [8:0][7:0]      wr_data_out;
    logic                 busy_out;
    logic                 done_out;
    logic [1:0]           state_dbg_out;

    // Request source / BRAM sink side
    modport master (
        output init_req_in, paint_req_in, erase_in, cursor_x_in, cursor_y_in,
        input  wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, state_dbg_out
    );

    // Painter side
    modport slave (
        input  init_req_in, paint_req_in, erase_in, cursor_x_in, cursor_y_in,
        output wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, state_dbg_out
    );
endinterface

// File: rtl/barrier_painter.sv
// Write-side stage for the fluid-state BRAM.
// After reset, and on request, it sweeps the whole grid to the equilibrium
// distribution. On a paint request it stamps a square brush of barrier cells
// (all densities 8'hFF) around the cursor. In erase mode it restores the
// brush cells to equilibrium instead. The stage writes one cell slot per clock.
module barrier_painter #(
    parameter int         GRID_W     = 205,
    parameter int         GRID_H     = 154,
    parameter int         BRAM_DEPTH = 31570,
    parameter int         BRUSH_R    = 2,
    parameter logic [7:0] INIT_REST  = 8'd112,
    parameter logic [7:0] INIT_AXIS  = 8'd28,
    parameter logic [7:0] INIT_DIAG  = 8'd7
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    barrier_painter_if.slave  bus
);

    localparam int AW   = $clog2(BRAM_DEPTH);
    localparam int SPAN = 2 * BRUSH_R + 1;
    // Brush offset counters run 0..SPAN-1; one extra code keeps CW >= 1 for R=0
    localparam int CW   = $clog2(SPAN + 1);

    localparam logic [CW-1:0]        SPAN_LAST = CW'(SPAN - 1);
    localparam logic [AW-1:0]        LAST_ADDR = AW'(BRAM_DEPTH - 1);
    localparam logic [AW-1:0]        ROW_MUL   = AW'(GRID_W);
    localparam logic signed [10:0]   R_S       = 11'(BRUSH_R);
    localparam logic signed [10:0]   GW_S      = 11'(GRID_W);
    localparam logic signed [10:0]   GH_S      = 11'(GRID_H);

    // Direction index: [0] rest, [4:1] axis E,N,W,S, [8:5] diagonals
    localparam logic [8:0][7:0] EQ_VEC = {INIT_DIAG, INIT_DIAG, INIT_DIAG, INIT_DIAG,
                                          INIT_AXIS, INIT_AXIS, INIT_AXIS, INIT_AXIS,
                                          INIT_REST};
    localparam logic [8:0][7:0] BARRIER_VEC = {9{8'hFF}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_PAINT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Control state
    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   sweep_addr_q, sweep_addr_d;
    logic [CW-1:0]   dx_q, dx_d;
    logic [CW-1:0]   dy_q, dy_d;
    logic [7:0]      cx_q, cx_d;
    logic [7:0]      cy_q, cy_d;
    logic            erase_q, erase_d;

    // Registered outputs
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [8:0][7:0] wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Brush cell coordinates for the current slot, signed so that cells
    // left of column 0 or above row 0 come out negative and get clipped
    logic signed [10:0] cell_x;
    logic signed [10:0] cell_y;
    logic               cell_valid;
    logic [AW-1:0]      cell_x_u;
    logic [AW-1:0]      cell_y_u;
    logic [AW-1:0]      cell_addr;

    // Map the brush offset counters to a grid cell and check it against the grid
    always_comb begin
        cell_x     = $signed({3'b000, cx_q}) + $signed(11'(dx_q)) - R_S;
        cell_y     = $signed({3'b000, cy_q}) + $signed(11'(dy_q)) - R_S;
        cell_valid = (cell_x >= 11'sd0) && (cell_x < GW_S) &&
                     (cell_y >= 11'sd0) && (cell_y < GH_S);
        cell_x_u   = AW'(cell_x[9:0]);
        cell_y_u   = AW'(cell_y[9:0]);
        // Only used when cell_valid, so the product stays below BRAM_DEPTH
        cell_addr  = cell_y_u * ROW_MUL + cell_x_u;
    end

    // Next-state logic for the FSM, the slot counters and the output registers
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        erase_d      = erase_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A full sweep takes priority; a paint in the same cycle is dropped
                if (bus.init_req_in) begin
                    state_d      = ST_INIT;
                    sweep_addr_d = '0;
                end else if (bus.paint_req_in) begin
                    state_d = ST_PAINT;
                    cx_d    = bus.cursor_x_in;
                    cy_d    = bus.cursor_y_in;
                    erase_d = bus.erase_in;
                    dx_d    = '0;
                    dy_d    = '0;
                end
            end

            ST_INIT: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = sweep_addr_q;
                wr_data_d = EQ_VEC;
                if (sweep_addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    sweep_addr_d = sweep_addr_q + AW'(1);
                end
            end

            ST_PAINT: begin
                busy_d = 1'b1;
                // Clipped slots still cost a cycle so the latency is position-independent
                if (cell_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cell_addr;
                    wr_data_d = erase_q ? EQ_VEC : BARRIER_VEC;
                end
                if (dx_q == SPAN_LAST) begin
                    dx_d = '0;
                    if (dy_q == SPAN_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        dy_d = dy_q + CW'(1);
                    end
                end else begin
                    dx_d = dx_q + CW'(1);
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset restarts the equilibrium sweep at address 0
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_INIT;
            sweep_addr_q <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            erase_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            erase_q      <= erase_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.wr_en_out     = wr_en_q;
    assign bus.wr_addr_out   = wr_addr_q;
    assign bus.wr_data_out   = wr_data_q;
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.state_dbg_out = state_q;

endmodule

// File: tb/tb_barrier_painter.sv
// Self-checking bench for barrier_painter: the expected BRAM writes go into a
// queue when a request is driven, and they are compared as the DUT writes.
module tb_barrier_painter;

    localparam int AW    = 15;
    localparam int GW    = 205;
    localparam int GH    = 154;
    localparam int DEPTH = 31570;
    localparam int R     = 2;

    localparam logic [71:0] EQ  = {8'd7, 8'd7, 8'd7, 8'd7, 8'd28, 8'd28, 8'd28, 8'd28, 8'd112};
    localparam logic [71:0] BAR = {9{8'hFF}};

    logic clk;
    logic rst_n;

    barrier_painter_if #(.AW(AW)) bus ();

    barrier_painter dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [AW+72-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int done_cnt = 0;
    int first_addr = 0;
    int last_addr  = 0;
    bit cap_first  = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare every enabled write against the head of the queue
    always @(negedge clk) begin
        logic [AW+72-1:0] e;
        if (bus.done_out) done_cnt++;
        if (bus.wr_en_out) begin
            wr_count++;
            last_addr = int'(bus.wr_addr_out);
            if (cap_first) begin
                first_addr = int'(bus.wr_addr_out);
                cap_first  = 1'b0;
            end
            check("wr_addr_in_range", bus.wr_addr_out < AW'(DEPTH), 1'b1);
            check("busy_during_write", bus.busy_out, 1'b1);
            check("write_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr_out, e[AW+71:72]);
                check("wr_data", bus.wr_data_out, e[71:0]);
            end
        end
    end

    task automatic push_sweep();
        for (int a = 0; a < DEPTH; a++) exp_q.push_back({AW'(a), EQ});
    endtask

    // Reference brush: row-major over the square, keeping in-grid cells only
    task automatic push_paint(input int cx, input int cy, input bit er, input int max_slots,
                              output int n, output int f, output int l);
        int slot;
        slot = 0; n = 0; f = 0; l = 0;
        for (int dy = -R; dy <= R; dy++) begin
            for (int dx = -R; dx <= R; dx++) begin
                int x, y, a;
                x = cx + dx;
                y = cy + dy;
                if (slot < max_slots && x >= 0 && x < GW && y >= 0 && y < GH) begin
                    a = x + GW * y;
                    if (n == 0) f = a;
                    l = a;
                    n++;
                    exp_q.push_back({AW'(a), er ? EQ : BAR});
                end
                slot++;
            end
        end
    endtask

    // Count clock edges until done_out is seen, bounded by budget
    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            seen = bus.done_out;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},   bus.wr_en_out,   1'b0);
        check({tag, "_wr_addr"}, bus.wr_addr_out, '0);
        check({tag, "_wr_data"}, bus.wr_data_out, '0);
        check({tag, "_busy"},    bus.busy_out,    1'b0);
        check({tag, "_done"},    bus.done_out,    1'b0);
    endtask

    // Paint driver; exp_n/exp_first/exp_last < 0 means take the reference brush values
    task automatic do_paint(input string tag, input int cx, input int cy, input bit er,
                            input int exp_n, input int exp_first, input int exp_last);
        int n, f, l, w0, cyc;
        bit seen;
        @(posedge clk);
        #1;
        bus.cursor_x_in  = 8'(cx);
        bus.cursor_y_in  = 8'(cy);
        bus.erase_in     = er;
        bus.paint_req_in = 1'b1;
        push_paint(cx, cy, er, 1000, n, f, l);
        if (exp_n >= 0)     n = exp_n;
        if (exp_first >= 0) f = exp_first;
        if (exp_last >= 0)  l = exp_last;
        cap_first = 1'b1;
        w0 = wr_count;
        @(posedge clk);
        #1;
        // Cursor and mode must already be latched; scramble them
        bus.paint_req_in = 1'b0;
        bus.cursor_x_in  = 8'($urandom_range(0, 255));
        bus.cursor_y_in  = 8'($urandom_range(0, 255));
        bus.erase_in     = ~er;
        wait_done(40, seen, cyc);
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_done_latency"}, 32'(cyc), 32'(26));
        check({tag, "_busy_at_done"}, bus.busy_out, 1'b0);
        check({tag, "_wr_en_at_done"}, bus.wr_en_out, 1'b0);
        check({tag, "_write_count"}, 32'(wr_count - w0), 32'(n));
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'(0));
        if (n > 0) begin
            check({tag, "_first_addr"}, 32'(first_addr), 32'(f));
            check({tag, "_last_addr"},  32'(last_addr),  32'(l));
        end
        cap_first = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int w0, d0, cyc, n, f, l;
        bit seen;

        rst_n            = 1'b0;
        bus.init_req_in  = 1'b0;
        bus.paint_req_in = 1'b0;
        bus.erase_in     = 1'b0;
        bus.cursor_x_in  = '0;
        bus.cursor_y_in  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        // Reset release sweep, with a paint request dropped in mid-sweep
        push_sweep();
        w0 = wr_count;
        d0 = done_cnt;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        bus.cursor_x_in  = 8'd30;
        bus.cursor_y_in  = 8'd30;
        bus.paint_req_in = 1'b1;
        @(posedge clk);
        #1;
        bus.paint_req_in = 1'b0;
        wait_done(32000, seen, cyc);
        check("sweep1_done_seen", seen, 1'b1);
        check("sweep1_latency", 32'(101 + cyc), 32'(DEPTH + 1));
        check("sweep1_write_count", 32'(wr_count - w0), 32'(DEPTH));
        check("sweep1_last_addr", 32'(last_addr), 32'(DEPTH - 1));
        repeat (3) @(negedge clk);
        check("sweep1_done_once", 32'(done_cnt - d0), 32'(1));
        check("sweep1_queue_drained", 32'(exp_q.size()), 32'(0));
        check("sweep1_idle_busy", bus.busy_out, 1'b0);
        check("sweep1_no_paint_after", 32'(wr_count - w0), 32'(DEPTH));

        // Directed paints
        do_paint("draw_100_50", 100, 50, 1'b0, 25, 9938, 10762);
        do_paint("draw_0_0", 0, 0, 1'b0, 9, 0, 412);
        do_paint("draw_204_153", 204, 153, 1'b0, 9, 31157, 31569);
        do_paint("draw_offgrid", 250, 200, 1'b0, 0, -1, -1);
        do_paint("draw_10_10", 10, 10, 1'b0, 25, 1648, 2472);
        do_paint("erase_10_10", 10, 10, 1'b1, 25, 1648, 2472);
        do_paint("erase_203_0", 203, 0, 1'b1, 12, 201, 614);
        for (int i = 0; i < 6; i++) begin
            do_paint("rand_paint", int'($urandom_range(0, 220)), int'($urandom_range(0, 170)),
                     1'($urandom_range(0, 1)), -1, -1, -1);
        end

        // Simultaneous init + paint: only the sweep runs
        @(posedge clk);
        #1;
        bus.cursor_x_in  = 8'd100;
        bus.cursor_y_in  = 8'd50;
        bus.erase_in     = 1'b0;
        bus.init_req_in  = 1'b1;
        bus.paint_req_in = 1'b1;
        push_sweep();
        w0 = wr_count;
        @(posedge clk);
        #1;
        bus.init_req_in  = 1'b0;
        bus.paint_req_in = 1'b0;
        wait_done(32000, seen, cyc);
        check("sweep2_done_seen", seen, 1'b1);
        check("sweep2_latency", 32'(cyc), 32'(DEPTH + 1));
        check("sweep2_write_count", 32'(wr_count - w0), 32'(DEPTH));
        repeat (30) @(negedge clk);
        check("sweep2_no_paint_after", 32'(wr_count - w0), 32'(DEPTH));
        check("sweep2_queue_drained", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of a paint, after slot 11 has been written
        @(posedge clk);
        #1;
        bus.cursor_x_in  = 8'd100;
        bus.cursor_y_in  = 8'd50;
        bus.erase_in     = 1'b0;
        bus.paint_req_in = 1'b1;
        push_paint(100, 50, 1'b0, 12, n, f, l);
        w0 = wr_count;
        @(posedge clk);
        #1;
        bus.paint_req_in = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        check("midreset_write_count", 32'(wr_count - w0), 32'(n));
        check("midreset_queue_drained", 32'(exp_q.size()), 32'(0));
        repeat (2) @(negedge clk);
        check_outputs_zero("midreset_hold");

        // After release the sweep restarts at address 0 with no paint writes left over
        push_sweep();
        w0 = wr_count;
        rst_n = 1'b1;
        cyc = 0;
        while ((wr_count - w0) < 1000 && cyc < 1200) begin
            @(negedge clk);
            cyc++;
        end
        check("resweep_progress", (wr_count - w0) >= 1000, 1'b1);
        check("resweep_busy", bus.busy_out, 1'b1);
        check("resweep_state_init", bus.state_dbg_out, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
